// File: rtl/sw_debounce_if.sv
// Switch-conditioning signal bundle between the switch debouncer and its
// software-facing register side.
interface sw_debounce_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] irq_mask;
    logic             irq;

    modport master (
        output sw_raw,
        output clear,
        output irq_mask,
        input  sw_clean,
        input  changed,
        input  irq
    );

    modport slave (
        input  sw_raw,
        input  clear,
        input  irq_mask,
        output sw_clean,
        output changed,
        output irq
    );
endinterface

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchronizer, per-bit debounce counter,
// sticky change flags with write-one-to-clear, and a maskable level interrupt.
module sw_debounce #(
    parameter  int WIDTH         = 10,
    parameter  int STABLE_CYCLES = 1000000,
    localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic          clk,
    input  logic          reset_n,
    sw_debounce_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_clean;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_changed;
    logic             r_irq;
    logic [WIDTH-1:0] w_accept;

    // A bit is accepted once it has disagreed with the clean level long enough.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (r_s2[i] != r_clean[i]) && (r_cnt[i] == LAST_CNT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.sw_raw;
            r_s2 <= r_s1;
        end
    end

    // Any return to the clean level restarts that bit's count from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clean <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_clean[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A new acceptance wins over a clear strobe arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_changed <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_changed <= (r_changed & ~bus.clear) | w_accept;
            r_irq     <= |(r_changed & bus.irq_mask);
        end
    end

    assign bus.sw_clean = r_clean;
    assign bus.changed  = r_changed;
    assign bus.irq      = r_irq;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed self-checking bench for sw_debounce with a short debounce window.
module tb_sw_debounce;
    localparam int WIDTH         = 10;
    localparam int STABLE_CYCLES = 8;

    logic clk;
    logic reset_n;
    int   checkCount;
    int   failCount;

    sw_debounce_if #(.WIDTH(WIDTH)) sif ();

    sw_debounce #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] clr,
                                 input logic [WIDTH-1:0] mask);
        sif.sw_raw   = raw;
        sif.clear    = clr;
        sif.irq_mask = mask;
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset_n    = 1'b0;
        applyStimulus(10'h000, 10'h000, 10'h3FF);
        tick(2);
        checkOutput("rst_clean", 32'(sif.sw_clean), 32'h000);
        checkOutput("rst_changed", 32'(sif.changed), 32'h000);
        checkOutput("rst_irq", 32'(sif.irq), 32'h0);
        reset_n = 1'b1;
        tick(3);
        checkOutput("idle_clean", 32'(sif.sw_clean), 32'h000);

        // Basic rise on bit 0
        applyStimulus(10'h001, 10'h000, 10'h3FF);
        tick(9);
        checkOutput("rise_e9_clean", 32'(sif.sw_clean), 32'h000);
        checkOutput("rise_e9_changed", 32'(sif.changed), 32'h000);
        tick(1);
        checkOutput("rise_e10_clean", 32'(sif.sw_clean), 32'h001);
        checkOutput("rise_e10_changed", 32'(sif.changed), 32'h001);
        checkOutput("rise_e10_irq", 32'(sif.irq), 32'h0);
        tick(1);
        checkOutput("rise_e11_irq", 32'(sif.irq), 32'h1);
        applyStimulus(10'h001, 10'h001, 10'h3FF);
        tick(1);
        checkOutput("rise_clr_changed", 32'(sif.changed), 32'h000);
        applyStimulus(10'h001, 10'h000, 10'h3FF);
        tick(1);
        checkOutput("rise_clr_irq", 32'(sif.irq), 32'h0);

        // Glitch rejection on bit 3
        for (int k = 0; k < 4; k++) begin
            applyStimulus(10'h009, 10'h000, 10'h3FF);
            tick(5);
            applyStimulus(10'h001, 10'h000, 10'h3FF);
            tick(5);
            checkOutput("glitch_clean", 32'(sif.sw_clean), 32'h001);
            checkOutput("glitch_changed", 32'(sif.changed), 32'h000);
            checkOutput("glitch_irq", 32'(sif.irq), 32'h0);
        end

        // Bounce on bit 9, then settle high
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 10'h201 : 10'h001, 10'h000, 10'h3FF);
            tick(3);
            checkOutput("bounce_clean", 32'(sif.sw_clean), 32'h001);
        end
        applyStimulus(10'h201, 10'h000, 10'h3FF);
        tick(9);
        checkOutput("settle_e9_clean", 32'(sif.sw_clean), 32'h001);
        checkOutput("settle_e9_changed", 32'(sif.changed), 32'h000);
        tick(1);
        checkOutput("settle_e10_clean", 32'(sif.sw_clean), 32'h201);
        checkOutput("settle_e10_changed", 32'(sif.changed), 32'h200);
        tick(1);
        checkOutput("settle_irq", 32'(sif.irq), 32'h1);
        applyStimulus(10'h201, 10'h200, 10'h3FF);
        tick(1);
        applyStimulus(10'h201, 10'h000, 10'h3FF);
        tick(1);
        checkOutput("settle_cleared", 32'(sif.changed), 32'h000);
        checkOutput("settle_irq_low", 32'(sif.irq), 32'h0);

        // Clear colliding with a falling acceptance on bit 0
        applyStimulus(10'h200, 10'h000, 10'h3FF);
        tick(10);
        checkOutput("coll_fall_changed", 32'(sif.changed), 32'h001);
        applyStimulus(10'h201, 10'h000, 10'h3FF);
        tick(10);
        checkOutput("coll_rise_clean", 32'(sif.sw_clean), 32'h201);
        applyStimulus(10'h200, 10'h000, 10'h3FF);
        tick(9);
        applyStimulus(10'h200, 10'h001, 10'h3FF);
        tick(1);
        checkOutput("coll_set_wins", 32'(sif.changed), 32'h001);
        checkOutput("coll_clean", 32'(sif.sw_clean), 32'h200);
        tick(1);
        checkOutput("coll_clear", 32'(sif.changed), 32'h000);
        applyStimulus(10'h200, 10'h000, 10'h3FF);
        tick(1);
        checkOutput("coll_irq", 32'(sif.irq), 32'h0);

        // Simultaneous acceptance on bits 1 and 2 with masking
        applyStimulus(10'h206, 10'h000, 10'h004);
        tick(9);
        checkOutput("multi_e9_changed", 32'(sif.changed), 32'h000);
        tick(1);
        checkOutput("multi_changed", 32'(sif.changed), 32'h006);
        checkOutput("multi_clean", 32'(sif.sw_clean), 32'h206);
        checkOutput("multi_e10_irq", 32'(sif.irq), 32'h0);
        tick(1);
        checkOutput("multi_irq", 32'(sif.irq), 32'h1);
        applyStimulus(10'h206, 10'h000, 10'h000);
        tick(1);
        checkOutput("mask_irq", 32'(sif.irq), 32'h0);
        applyStimulus(10'h206, 10'h000, 10'h002);
        tick(1);
        checkOutput("unmask_irq", 32'(sif.irq), 32'h1);
        applyStimulus(10'h206, 10'h006, 10'h002);
        tick(1);
        checkOutput("multi_clear", 32'(sif.changed), 32'h000);

        // Asynchronous reset in the middle of a count on bit 5
        applyStimulus(10'h020, 10'h000, 10'h3FF);
        tick(6);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_clean", 32'(sif.sw_clean), 32'h000);
        checkOutput("async_changed", 32'(sif.changed), 32'h000);
        checkOutput("async_irq", 32'(sif.irq), 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(9);
        checkOutput("rel_e9_clean", 32'(sif.sw_clean), 32'h000);
        tick(1);
        checkOutput("rel_e10_clean", 32'(sif.sw_clean), 32'h020);
        checkOutput("rel_e10_changed", 32'(sif.changed), 32'h020);
        tick(1);
        checkOutput("rel_irq", 32'(sif.irq), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
